fault_syndrome_mon: RTL
=======================

FAULT_SYNDROME_MON -- requirements
Module: fault_syndrome_mon

Interface
REQ-001 Parameter WIDTH, default 4: adder bit-slices monitored, range 2..32.
REQ-002 Parameter CONFIRM, default 2: consecutive mismatching checks needed to confirm a fault, range 1..15.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-low.
REQ-005 chk_valid  in  1  compare strobe; sf/cf/exp_s/exp_c sampled only when high.
REQ-006 sf  in  WIDTH  observed sum bits from adder under test.
REQ-007 cf  in  WIDTH  observed carry bits from adder under test.
REQ-008 exp_s  in  WIDTH  expected sum bits from test-pattern source.
REQ-009 exp_c  in  WIDTH  expected carry bits from test-pattern source.
REQ-010 flt_ack  in  1  host acknowledge; clears confirmed fault state.
REQ-011 fault_flags  out  2*WIDTH  sticky flags; bit 2i = carry slice i, bit 2i+1 = sum slice i.
REQ-012 stage_sel  out  WIDTH  stage_sel[i] = fault_flags[2i+1] | fault_flags[2i].
REQ-013 iso_mask  out  WIDTH  prefix OR: iso_mask[i] = OR of stage_sel[0..i].
REQ-014 fault_req  out  1  high while a confirmed fault awaits flt_ack.
REQ-015 first_idx  out  clog2(WIDTH)  lowest faulty slice index at confirmation.

Function
REQ-016 Mismatch vector m = {interleaved (sf^exp_s),(cf^exp_c)}, 2*WIDTH bits, evaluated only when chk_valid=1; any bit set = mismatching check.
REQ-017 FSM states MON, SUSPECT, LOCKED; reset state MON.
REQ-018 MON: mismatching check -> SUSPECT with miss_cnt=1 and pend=m; if CONFIRM=1 -> LOCKED directly, fault_flags loaded with m.
REQ-019 SUSPECT: mismatching check -> miss_cnt+1, pend|=m; when miss_cnt+1 = CONFIRM -> LOCKED, fault_flags loaded with pend|m.
REQ-020 SUSPECT: clean check (chk_valid=1, m=0) -> MON, miss_cnt and pend cleared (transient discarded).
REQ-021 Any state, chk_valid=0: state, miss_cnt, pend, fault_flags held.
REQ-022 LOCKED: each mismatching check ORs m into fault_flags; fault_req=1; first_idx frozen at value computed on entry.
REQ-023 LOCKED with flt_ack=1 -> MON next cycle, fault_flags, pend, miss_cnt, first_idx cleared; ack wins over a simultaneous mismatch (that check discarded).
REQ-024 flt_ack outside LOCKED has no effect.
REQ-025 Latency: outputs are functions of registered state only; fault visible on fault_flags/fault_req the cycle after the confirming check.
REQ-026 miss_cnt width clog2(CONFIRM+1); never wraps.

Reset
REQ-027 clr low: state=MON, miss_cnt=0, pend=0, fault_flags=0, first_idx=0, fault_req=0, stage_sel=0, iso_mask=0 (and fault_cnt=0), immediately and independent of clk.
REQ-028 Reset mid-SUSPECT or mid-LOCKED discards all pending and confirmed faults.

Configuration
REQ-029 Macro FAULT_SYNDROME_CNT_EN defined: extra output fault_cnt, 8 bits, increments on every MON/SUSPECT->LOCKED transition, saturates at 255, cleared only by reset.
REQ-030 Macro undefined: fault_cnt port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared package holds FSM state enum (MON, SUSPECT, LOCKED) and FAULT_CNT_W=8 constant.
REQ-032 One sub-module, syndrome_reduce: combinational stage_sel, iso_mask and lowest-set-index encoder from a 2*WIDTH flag vector.

Verification (WIDTH=4, CONFIRM=2)
REQ-033 Single-check glitch: one check sf=4'b0100, exp_s=4'b0000, then clean check -> state MON, fault_flags=0, fault_req=0.
REQ-034 Confirmed fault: two consecutive checks cf=4'b0010 vs exp_c=0 -> fault_flags=8'h04, stage_sel=4'b0010, iso_mask=4'b1110, first_idx=1, fault_req=1 one cycle after second check.
REQ-035 Accumulation in LOCKED: then check sf=4'b1000 vs 0 -> fault_flags=8'h84, stage_sel=4'b1010, first_idx stays 1.
REQ-036 Ack vs mismatch collision: flt_ack=1 with mismatching check in LOCKED -> next cycle all flags 0, state MON, fault_req=0.
REQ-037 Async reset: clr low between clock edges in LOCKED -> all outputs 0 before next edge; with FAULT_SYNDROME_CNT_EN, 300 confirm/ack cycles -> fault_cnt=255.

Source files
------------

// File: rtl/fault_syndrome_mon_pkg.sv
// Shared types and constants for the fault syndrome monitor.
package fault_syndrome_mon_pkg;

  typedef enum logic [1:0] {
    MON     = 2'd0,
    SUSPECT = 2'd1,
    LOCKED  = 2'd2
  } fsm_state_e;

  localparam int unsigned FAULT_CNT_W = 8;

endpackage

// File: rtl/fault_syndrome_mon_reduce.sv
// Combinational reduction of an interleaved sum/carry flag vector into
// per-stage select, prefix isolation mask and lowest faulty slice index.
module syndrome_reduce #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [2*WIDTH-1:0] flags,
  output logic [WIDTH-1:0]   stage_sel,
  output logic [WIDTH-1:0]   iso_mask,
  output logic [IDX_W-1:0]   low_idx
);

  logic acc;
  logic found;

  always_comb begin
    stage_sel = '0;
    iso_mask  = '0;
    low_idx   = '0;
    acc       = 1'b0;
    found     = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      stage_sel[i] = flags[2*i+1] | flags[2*i];
      acc          = acc | stage_sel[i];
      iso_mask[i]  = acc;
      if (stage_sel[i] && !found) begin
        low_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fault_syndrome_mon.sv
// Adder fault syndrome monitor: debounces sum/carry mismatches, latches
// sticky fault flags until acknowledged. Optional FAULT_SYNDROME_CNT_EN adds fault_cnt.
module fault_syndrome_mon
  import fault_syndrome_mon_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CONFIRM = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       chk_valid,
  input  logic [WIDTH-1:0]           sf,
  input  logic [WIDTH-1:0]           cf,
  input  logic [WIDTH-1:0]           exp_s,
  input  logic [WIDTH-1:0]           exp_c,
  input  logic                       flt_ack,
  output logic [2*WIDTH-1:0]         fault_flags,
  output logic [WIDTH-1:0]           stage_sel,
  output logic [WIDTH-1:0]           iso_mask,
  output logic                       fault_req,
  output logic [$clog2(WIDTH)-1:0]   first_idx
`ifdef FAULT_SYNDROME_CNT_EN
  ,
  output logic [FAULT_CNT_W-1:0]     fault_cnt
`endif
);

  localparam int unsigned IDX_W  = $clog2(WIDTH);
  localparam int unsigned MISS_W = $clog2(CONFIRM + 1);

  fsm_state_e          state_q, state_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d, miss_inc;
  logic [2*WIDTH-1:0]  pend_q, pend_d;
  logic [2*WIDTH-1:0]  flags_q, flags_d;
  logic [WIDTH-1:0]    stage_sel_q, stage_sel_d;
  logic [WIDTH-1:0]    iso_mask_q, iso_mask_d;
  logic [IDX_W-1:0]    first_idx_q, first_idx_d, low_idx;
  logic                fault_req_q, fault_req_d;
  logic [2*WIDTH-1:0]  m;
  logic                ack_clr;
  logic                enter_lock;

  always_comb begin
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      m[2*i]   = cf[i] ^ exp_c[i];
      m[2*i+1] = sf[i] ^ exp_s[i];
    end
  end

  assign miss_inc = miss_cnt_q + MISS_W'(1);
  assign ack_clr  = (state_q == LOCKED) && flt_ack;

  // Ack takes priority over any check presented in the same cycle.
  always_comb begin
    state_d    = state_q;
    miss_cnt_d = miss_cnt_q;
    pend_d     = pend_q;
    flags_d    = flags_q;
    if (ack_clr) begin
      state_d    = MON;
      miss_cnt_d = '0;
      pend_d     = '0;
      flags_d    = '0;
    end else if (chk_valid) begin
      unique case (state_q)
        MON: begin
          if (|m) begin
            miss_cnt_d = MISS_W'(1);
            pend_d     = m;
            if (CONFIRM == 1) begin
              state_d = LOCKED;
              flags_d = m;
            end else begin
              state_d = SUSPECT;
            end
          end
        end
        SUSPECT: begin
          if (|m) begin
            miss_cnt_d = miss_inc;
            pend_d     = pend_q | m;
            if (miss_inc == MISS_W'(CONFIRM)) begin
              state_d = LOCKED;
              flags_d = pend_q | m;
            end
          end else begin
            state_d    = MON;
            miss_cnt_d = '0;
            pend_d     = '0;
          end
        end
        LOCKED: flags_d = flags_q | m;
        default: begin
          state_d    = MON;
          miss_cnt_d = '0;
          pend_d     = '0;
          flags_d    = '0;
        end
      endcase
    end
  end

  // Reduction runs on next-state flags so derived outputs register alongside them.
  syndrome_reduce #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_reduce (
    .flags     (flags_d),
    .stage_sel (stage_sel_d),
    .iso_mask  (iso_mask_d),
    .low_idx   (low_idx)
  );

  assign enter_lock = (state_q != LOCKED) && (state_d == LOCKED);

  always_comb begin
    first_idx_d = first_idx_q;
    if (ack_clr) begin
      first_idx_d = '0;
    end else if (enter_lock) begin
      first_idx_d = low_idx;
    end
    fault_req_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= MON;
      miss_cnt_q  <= '0;
      pend_q      <= '0;
      flags_q     <= '0;
      stage_sel_q <= '0;
      iso_mask_q  <= '0;
      first_idx_q <= '0;
      fault_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_cnt_q  <= miss_cnt_d;
      pend_q      <= pend_d;
      flags_q     <= flags_d;
      stage_sel_q <= stage_sel_d;
      iso_mask_q  <= iso_mask_d;
      first_idx_q <= first_idx_d;
      fault_req_q <= fault_req_d;
    end
  end

  assign fault_flags = flags_q;
  assign stage_sel   = stage_sel_q;
  assign iso_mask    = iso_mask_q;
  assign fault_req   = fault_req_q;
  assign first_idx   = first_idx_q;

`ifdef FAULT_SYNDROME_CNT_EN
  logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (enter_lock && (fault_cnt_q != '1)) begin
      fault_cnt_d = fault_cnt_q + FAULT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fault_cnt_q <= '0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign fault_cnt = fault_cnt_q;
`endif

endmodule
